// File: rtl/mest_pro_fetch_ctrl.sv
// Fetch/decode sequencer: fetches 20-bit words, issues them to execute,
// then resolves the next PC from jump/return/halt flags with a return-address stack.
module mest_pro_fetch_ctrl #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  output logic [PC_W-1:0]  o_imem_addr,
  output logic             o_imem_rd,
  input  logic [19:0]      i_imem_data,
  output logic             o_execute,
  output logic [3:0]       o_op_code,
  output logic [7:0]       o_operand1,
  output logic [7:0]       o_operand2,
  input  logic             i_exec_done,
  input  logic             i_jump,
  input  logic             i_return_pc,
  input  logic             i_end_of_code,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_halted,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_instr_count
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MEM, S_ISSUE, S_WAIT, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [PC_W-1:0]  stack [STACK_DEPTH];
  logic [SP_W-1:0]  sp, sp_nx;
  logic [PC_W-1:0]  pc_nx, pc_inc, stack_top;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic             stack_full, stack_empty, push;
  logic             fault_nx;
  logic [CNT_W-1:0] count_nx, count_inc;
  logic [3:0]       op_nx;
  logic [7:0]       op1_nx, op2_nx;
  logic [PC_W-1:0]  imem_addr_nx;

  assign pc_inc      = o_pc + PC_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));
  assign stack_top   = stack[pop_idx];
  assign count_inc   = (&o_instr_count) ? o_instr_count : o_instr_count + CNT_W'(1);

  always_comb begin
    state_nx = state;
    pc_nx    = o_pc;
    sp_nx    = sp;
    push     = 1'b0;
    fault_nx = o_fault;
    count_nx = o_instr_count;
    op_nx    = o_op_code;
    op1_nx   = o_operand1;
    op2_nx   = o_operand2;

    case (state)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
          sp_nx    = '0;
          fault_nx = 1'b0;
          count_nx = '0;
        end
      end
      S_FETCH: state_nx = S_MEM;
      S_MEM: begin
        state_nx                = S_ISSUE;
        {op_nx, op1_nx, op2_nx} = i_imem_data;
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // Flags only matter together with done; halt wins over jump over return.
        if (i_exec_done) begin
          if (i_end_of_code) begin
            state_nx = S_HALT;
          end else if (i_jump) begin
            if (stack_full) begin
              fault_nx = 1'b1;
              state_nx = S_HALT;
            end else begin
              push     = 1'b1;
              sp_nx    = sp + SP_W'(1);
              pc_nx    = o_operand1[PC_W-1:0];
              count_nx = count_inc;
              state_nx = S_FETCH;
            end
          end else if (i_return_pc) begin
            if (stack_empty) begin
              fault_nx = 1'b1;
              state_nx = S_HALT;
            end else begin
              sp_nx    = sp - SP_W'(1);
              pc_nx    = stack_top;
              count_nx = count_inc;
              state_nx = S_FETCH;
            end
          end else begin
            pc_nx    = pc_inc;
            count_nx = count_inc;
            state_nx = S_FETCH;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign imem_addr_nx = (state_nx == S_FETCH) ? pc_nx : o_imem_addr;

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      o_pc          <= '0;
      sp            <= '0;
      o_fault       <= 1'b0;
      o_instr_count <= '0;
      o_op_code     <= '0;
      o_operand1    <= '0;
      o_operand2    <= '0;
      o_imem_addr   <= '0;
      o_imem_rd     <= 1'b0;
      o_execute     <= 1'b0;
      o_halted      <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      state         <= state_nx;
      o_pc          <= pc_nx;
      sp            <= sp_nx;
      o_fault       <= fault_nx;
      o_instr_count <= count_nx;
      o_op_code     <= op_nx;
      o_operand1    <= op1_nx;
      o_operand2    <= op2_nx;
      o_imem_addr   <= imem_addr_nx;
      o_imem_rd     <= (state_nx == S_FETCH);
      o_execute     <= (state_nx == S_ISSUE);
      o_halted      <= (state_nx == S_HALT);
      if (push) stack[push_idx] <= pc_inc;
    end
  end

endmodule
